// File: rtl/txll_arb.sv
// txll_arb: frame-level arbiter in front of the SATA TX link FIFO.
// Two sources, whole-frame grants, almost-full and frame-count throttling.
module txll_arb #(
  parameter int C_MAX_FRAMES = 4,
  parameter bit C_PRIO0      = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        phyreset,
  input  logic        req0_valid,
  input  logic        req0_sof,
  input  logic        req0_eof,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_sof,
  input  logic        req1_eof,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [31:0] txfifo_data,
  output logic        txfifo_sof,
  output logic        txfifo_eof,
  output logic        txfifo_wr_en,
  input  logic        txfifo_almost_full,
  input  logic        txfifo_eof_poped,
  output logic [3:0]  frames_pending,
  output logic [1:0]  grant,
  output logic        proto_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;
  localparam logic [3:0] LP_MAX = 4'(C_MAX_FRAMES);

  logic [0:0]  r_state;
  logic [1:0]  r_grant;
  logic        r_last;
  logic        r_active;
  logic [3:0]  r_pending;
  logic [31:0] r_data;
  logic        r_sof;
  logic        r_eof;
  logic        r_wr;
  logic        r_perr;

  logic        w_idle;
  logic        w_req0;
  logic        w_req1;
  logic        w_room;
  logic        w_go;
  logic        w_pick1;
  logic        w_drop0;
  logic        w_drop1;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_acc;
  logic [31:0] w_bdata;
  logic        w_bsof;
  logic        w_beof;
  logic        w_inc;
  logic        w_dec;

  assign w_idle = (r_state == S_IDLE);
  assign w_req0 = req0_valid & req0_sof;
  assign w_req1 = req1_valid & req1_sof;
  assign w_room = (r_pending < LP_MAX) & ~txfifo_almost_full;
  assign w_go   = w_idle & (w_req0 | w_req1) & w_room;

  // A headless beat seen while idle is swallowed, channel 0 first.
  assign w_drop0 = r_active & w_idle & req0_valid & ~req0_sof;
  assign w_drop1 = r_active & w_idle & req1_valid & ~req1_sof
                 & ~w_drop0;

  assign req0_ready = (r_grant[0] & ~txfifo_almost_full) | w_drop0;
  assign req1_ready = (r_grant[1] & ~txfifo_almost_full) | w_drop1;

  assign w_acc0 = req0_valid & r_grant[0] & ~txfifo_almost_full;
  assign w_acc1 = req1_valid & r_grant[1] & ~txfifo_almost_full;
  assign w_acc  = w_acc0 | w_acc1;

  assign w_bdata = w_acc1 ? req1_data : req0_data;
  assign w_bsof  = w_acc1 ? req1_sof  : req0_sof;
  assign w_beof  = w_acc1 ? req1_eof  : req0_eof;

  assign w_inc = w_acc & w_beof;
  assign w_dec = txfifo_eof_poped & (r_pending != 4'd0);

  // Choose the winner among sof requests seen while idle.
  always_comb begin
    w_pick1 = 1'b0;
    unique case (1'b1)
      (w_req0 & w_req1):  w_pick1 = C_PRIO0 ? 1'b0 : ~r_last;
      (w_req1 & ~w_req0): w_pick1 = 1'b1;
      default:            w_pick1 = 1'b0;
    endcase
  end

  // Grant FSM: IDLE picks a frame owner, XFER holds it until eof.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (phyreset) begin
        r_state <= S_IDLE;
        r_grant <= 2'b00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_go) begin
              r_grant <= w_pick1 ? 2'b10 : 2'b01;
              r_last  <= w_pick1;
              r_state <= S_XFER;
            end
          end
          S_XFER: begin
            if (w_inc) begin
              r_grant <= 2'b00;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_grant <= 2'b00;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Count frames written to the FIFO but not yet popped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pending <= 4'd0;
    end else if (phyreset) begin
      r_pending <= 4'd0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pending <= r_pending + 4'd1;
        2'b01:   r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Register accepted beats onto the FIFO write port.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data <= 32'd0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
      r_wr   <= 1'b0;
      r_perr <= 1'b0;
    end else if (phyreset) begin
      r_data <= 32'd0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
      r_wr   <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_wr   <= w_acc;
      r_sof  <= w_acc & w_bsof;
      r_eof  <= w_acc & w_beof;
      r_perr <= w_drop0 | w_drop1;
      if (w_acc) begin
        r_data <= w_bdata;
      end
    end
  end

  assign txfifo_data    = r_data;
  assign txfifo_sof     = r_sof;
  assign txfifo_eof     = r_eof;
  assign txfifo_wr_en   = r_wr;
  assign frames_pending = r_pending;
  assign grant          = r_grant;
  assign proto_err      = r_perr;

endmodule

// File: tb/tb_txll_arb.sv
// tb_txll_arb: directed bench for txll_arb.
// dut_a: 2 frames max, round-robin; dut_b: 4 frames max, ch0 priority.
module tb_txll_arb;

  logic        clk;
  logic        rst_n;
  logic        phyreset;
  logic        v0, s0, e0, v1, s1, e1;
  logic [31:0] d0, d1;
  logic        af, pop;

  logic        a_rdy0, a_rdy1, a_sof, a_eof, a_wr, a_perr;
  logic [31:0] a_data;
  logic [3:0]  a_pend;
  logic [1:0]  a_grant;
  logic        b_rdy0, b_rdy1, b_sof, b_eof, b_wr, b_perr;
  logic [31:0] b_data;
  logic [3:0]  b_pend;
  logic [1:0]  b_grant;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] lg_d[$];
  bit          lg_s[$];
  bit          lg_e[$];
  int          lg_c[$];

  txll_arb #(.C_MAX_FRAMES(2), .C_PRIO0(1'b0)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .phyreset(phyreset),
    .req0_valid(v0), .req0_sof(s0), .req0_eof(e0),
    .req0_data(d0), .req0_ready(a_rdy0),
    .req1_valid(v1), .req1_sof(s1), .req1_eof(e1),
    .req1_data(d1), .req1_ready(a_rdy1),
    .txfifo_data(a_data), .txfifo_sof(a_sof), .txfifo_eof(a_eof),
    .txfifo_wr_en(a_wr), .txfifo_almost_full(af),
    .txfifo_eof_poped(pop), .frames_pending(a_pend),
    .grant(a_grant), .proto_err(a_perr)
  );

  txll_arb #(.C_MAX_FRAMES(4), .C_PRIO0(1'b1)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .phyreset(phyreset),
    .req0_valid(v0), .req0_sof(s0), .req0_eof(e0),
    .req0_data(d0), .req0_ready(b_rdy0),
    .req1_valid(v1), .req1_sof(s1), .req1_eof(e1),
    .req1_data(d1), .req1_ready(b_rdy1),
    .txfifo_data(b_data), .txfifo_sof(b_sof), .txfifo_eof(b_eof),
    .txfifo_wr_en(b_wr), .txfifo_almost_full(af),
    .txfifo_eof_poped(pop), .frames_pending(b_pend),
    .grant(b_grant), .proto_err(b_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; phyreset = 1'b0;
    v0 = 0; s0 = 0; e0 = 0; d0 = '0;
    v1 = 0; s1 = 0; e1 = 0; d1 = '0;
    af = 0; pop = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Both channels stream frames; the selected DUT's ready paces them.
  task automatic run_two(input bit use_b, input int n0, input int n1,
                         input int nb);
    int f0, f1, b0, b1;
    bit r0, r1, wr, sf, ef, done;
    logic [31:0] dd;
    f0 = 0; f1 = 0; b0 = 0; b1 = 0; done = 0;
    lg_d.delete(); lg_s.delete(); lg_e.delete(); lg_c.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      v0 = (f0 < n0); s0 = (b0 == 0); e0 = (b0 == nb - 1);
      d0 = {16'hC000, 8'(f0), 8'(b0)};
      v1 = (f1 < n1); s1 = (b1 == 0); e1 = (b1 == nb - 1);
      d1 = {16'hD000, 8'(f1), 8'(b1)};
      #1;
      r0 = use_b ? b_rdy0 : a_rdy0;
      r1 = use_b ? b_rdy1 : a_rdy1;
      @(posedge clk); #1;
      if (v0 && r0) begin
        if (b0 == nb - 1) begin b0 = 0; f0++; end else b0++;
      end
      if (v1 && r1) begin
        if (b1 == nb - 1) begin b1 = 0; f1++; end else b1++;
      end
      wr = use_b ? b_wr : a_wr;
      sf = use_b ? b_sof : a_sof;
      ef = use_b ? b_eof : a_eof;
      dd = use_b ? b_data : a_data;
      if (wr) begin
        lg_d.push_back(dd); lg_s.push_back(sf);
        lg_e.push_back(ef); lg_c.push_back(cyc);
      end
      if (f0 >= n0 && f1 >= n1) begin done = 1; break; end
    end
    v0 = 0; v1 = 0; s0 = 0; s1 = 0; e0 = 0; e1 = 0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL run_timeout got f0=%0d f1=%0d exp %0d %0d",
               f0, f1, n0, n1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a_rdy0, a_rdy1, a_grant, a_pend, a_wr, a_sof, a_eof, a_perr,
         a_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_a got g=%b p=%0d wr=%b d=%h exp 0",
               a_grant, a_pend, a_wr, a_data);
    end
    n_checks++;
    if ({b_rdy0, b_rdy1, b_grant, b_pend, b_wr, b_perr} !== '0) begin
      n_errors++;
      $display("FAIL reset_b got g=%b p=%0d wr=%b exp 0",
               b_grant, b_pend, b_wr);
    end
    pop = 1; @(posedge clk); #1; pop = 0;
    n_checks++;
    if (a_pend !== 4'd0) begin
      n_errors++;
      $display("FAIL pop_at_zero got %0d exp 0", a_pend);
    end
  endtask

  task automatic test_single();
    logic [31:0] x;
    do_reset();
    v0 = 1; s0 = 1; e0 = 0; d0 = 32'hA0; #1;
    n_checks++;
    if ({a_grant, a_rdy0} !== 3'b000) begin
      n_errors++;
      $display("FAIL single_req got g=%b r=%b exp 00 0", a_grant, a_rdy0);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({a_grant, a_rdy0, a_wr} !== 4'b0110) begin
      n_errors++;
      $display("FAIL single_grant got g=%b r=%b wr=%b exp 01 1 0",
               a_grant, a_rdy0, a_wr);
    end
    for (int i = 0; i < 4; i++) begin
      x = 32'hA0 + 32'(i);
      s0 = (i == 0); e0 = (i == 3); d0 = x;
      @(posedge clk); #1;
      n_checks++;
      if ({a_wr, a_data, a_sof, a_eof} !==
          {1'b1, x, (i == 0), (i == 3)}) begin
        n_errors++;
        $display("FAIL single_beat%0d got wr=%b d=%h s=%b e=%b exp d=%h",
                 i, a_wr, a_data, a_sof, a_eof, x);
      end
    end
    v0 = 0; e0 = 0;
    n_checks++;
    if ({a_grant, a_pend} !== {2'b00, 4'd1}) begin
      n_errors++;
      $display("FAIL single_end got g=%b p=%0d exp 00 1", a_grant, a_pend);
    end
    @(posedge clk); #1;
    n_checks++;
    if (a_wr !== 1'b0) begin
      n_errors++;
      $display("FAIL single_idle_wr got %b exp 0", a_wr);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] ed;
    int k, g;
    do_reset();
    pop = 1;
    run_two(1'b0, 2, 2, 2);
    pop = 0;
    n_checks++;
    if (lg_d.size() != 8) begin
      n_errors++;
      $display("FAIL rr_count got %0d exp 8", lg_d.size());
    end
    for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
      k = i / 2;
      ed = {(k % 2) ? 16'hD000 : 16'hC000, 8'(k / 2), 8'(i % 2)};
      n_checks++;
      if ({lg_d[i], lg_s[i], lg_e[i]} !==
          {ed, (i % 2 == 0), (i % 2 == 1)}) begin
        n_errors++;
        $display("FAIL rr_beat%0d got %h s=%b e=%b exp %h",
                 i, lg_d[i], lg_s[i], lg_e[i], ed);
      end
      if (i > 0) begin
        g = (i % 2 == 0) ? 2 : 1;
        n_checks++;
        if (lg_c[i] - lg_c[i-1] != g) begin
          n_errors++;
          $display("FAIL rr_gap%0d got %0d exp %0d",
                   i, lg_c[i] - lg_c[i-1], g);
        end
      end
    end
  endtask

  task automatic test_prio();
    logic [31:0] ed;
    int k;
    do_reset();
    pop = 1;
    run_two(1'b1, 3, 1, 2);
    pop = 0;
    n_checks++;
    if (lg_d.size() != 8) begin
      n_errors++;
      $display("FAIL prio_count got %0d exp 8", lg_d.size());
    end
    for (int i = 0; i < 8 && i < lg_d.size(); i++) begin
      k = i / 2;
      ed = {(k == 3) ? 16'hD000 : 16'hC000, 8'((k == 3) ? 0 : k),
            8'(i % 2)};
      n_checks++;
      if ({lg_d[i], lg_s[i], lg_e[i]} !==
          {ed, (i % 2 == 0), (i % 2 == 1)}) begin
        n_errors++;
        $display("FAIL prio_beat%0d got %h exp %h", i, lg_d[i], ed);
      end
    end
    if (lg_c.size() == 8) begin
      n_checks++;
      if (lg_c[6] - lg_c[5] != 2) begin
        n_errors++;
        $display("FAIL prio_ch1_gap got %0d exp 2", lg_c[6] - lg_c[5]);
      end
    end
  endtask

  task automatic test_max_frames();
    do_reset();
    run_two(1'b0, 2, 0, 1);
    n_checks++;
    if (a_pend !== 4'd2) begin
      n_errors++;
      $display("FAIL max_full got %0d exp 2", a_pend);
    end
    v0 = 1; s0 = 1; e0 = 1; d0 = 32'hE0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({a_rdy0, a_grant, a_pend} !== {1'b0, 2'b00, 4'd2}) begin
        n_errors++;
        $display("FAIL max_hold%0d got r=%b g=%b p=%0d exp 0 00 2",
                 k, a_rdy0, a_grant, a_pend);
      end
    end
    pop = 1; @(posedge clk); #1; pop = 0;
    n_checks++;
    if ({a_grant, a_pend} !== {2'b00, 4'd1}) begin
      n_errors++;
      $display("FAIL max_pop got g=%b p=%0d exp 00 1", a_grant, a_pend);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({a_grant, a_rdy0} !== 3'b011) begin
      n_errors++;
      $display("FAIL max_regrant got g=%b r=%b exp 01 1", a_grant, a_rdy0);
    end
    @(posedge clk); #1; v0 = 0;
    n_checks++;
    if ({a_wr, a_data, a_grant, a_pend} !==
        {1'b1, 32'hE0, 2'b00, 4'd2}) begin
      n_errors++;
      $display("FAIL max_write got wr=%b d=%h p=%0d exp 1 e0 2",
               a_wr, a_data, a_pend);
    end
  endtask

  task automatic test_almost_full();
    logic [31:0] x;
    do_reset();
    run_two(1'b0, 1, 0, 1);
    v0 = 1; s0 = 1; e0 = 0; d0 = 32'hF0;
    @(posedge clk); #1;
    n_checks++;
    if (a_grant !== 2'b01) begin
      n_errors++;
      $display("FAIL af_grant got %b exp 01", a_grant);
    end
    for (int i = 0; i < 2; i++) begin
      x = 32'hF0 + 32'(i);
      s0 = (i == 0); d0 = x;
      @(posedge clk); #1;
      n_checks++;
      if ({a_wr, a_data} !== {1'b1, x}) begin
        n_errors++;
        $display("FAIL af_pre%0d got wr=%b d=%h exp %h", i, a_wr, a_data, x);
      end
    end
    af = 1; s0 = 0; d0 = 32'hF2; #1;
    n_checks++;
    if (a_rdy0 !== 1'b0) begin
      n_errors++;
      $display("FAIL af_rise_ready got %b exp 0", a_rdy0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({a_wr, a_rdy0} !== 2'b00) begin
        n_errors++;
        $display("FAIL af_stall%0d got wr=%b r=%b exp 0 0", k, a_wr, a_rdy0);
      end
    end
    af = 0;
    for (int i = 2; i < 5; i++) begin
      x = 32'hF0 + 32'(i);
      e0 = (i == 4); d0 = x; pop = (i == 4);
      @(posedge clk); #1;
      pop = 0;
      n_checks++;
      if ({a_wr, a_data, a_sof, a_eof} !== {1'b1, x, 1'b0, (i == 4)}) begin
        n_errors++;
        $display("FAIL af_post%0d got wr=%b d=%h e=%b exp %h",
                 i, a_wr, a_data, a_eof, x);
      end
    end
    v0 = 0; e0 = 0;
    n_checks++;
    if ({a_pend, a_grant} !== {4'd1, 2'b00}) begin
      n_errors++;
      $display("FAIL af_inc_dec got p=%0d g=%b exp 1 00", a_pend, a_grant);
    end
  endtask

  task automatic test_phyreset();
    do_reset();
    run_two(1'b0, 1, 0, 1);
    v0 = 1; s0 = 1; e0 = 0; d0 = 32'h50;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      s0 = (i == 0); d0 = 32'h50 + 32'(i);
      @(posedge clk); #1;
    end
    n_checks++;
    if ({a_wr, a_data, a_pend} !== {1'b1, 32'h51, 4'd1}) begin
      n_errors++;
      $display("FAIL phy_pre got wr=%b d=%h p=%0d exp 1 51 1",
               a_wr, a_data, a_pend);
    end
    s0 = 0; d0 = 32'h52; phyreset = 1;
    @(posedge clk); #1; phyreset = 0;
    n_checks++;
    if ({a_grant, a_pend, a_wr} !== 7'd0) begin
      n_errors++;
      $display("FAIL phy_flush got g=%b p=%0d wr=%b exp 00 0 0",
               a_grant, a_pend, a_wr);
    end
    n_checks++;
    if ({a_rdy0, a_perr} !== 2'b10) begin
      n_errors++;
      $display("FAIL drop_ready got r=%b pe=%b exp 1 0", a_rdy0, a_perr);
    end
    @(posedge clk); #1; v0 = 0; #1;
    n_checks++;
    if ({a_perr, a_wr, a_rdy0} !== 3'b100) begin
      n_errors++;
      $display("FAIL drop_pulse got pe=%b wr=%b r=%b exp 1 0 0",
               a_perr, a_wr, a_rdy0);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({a_perr, a_wr} !== 2'b00) begin
      n_errors++;
      $display("FAIL drop_once got pe=%b wr=%b exp 0 0", a_perr, a_wr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run_two(1'b0, 1, 0, 1);
    v0 = 1; s0 = 1; e0 = 0; d0 = 32'h60;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s0 = 0; d0 = 32'h61;
    n_checks++;
    if ({a_wr, a_sof, a_data, a_pend} !== {2'b11, 32'h60, 4'd1}) begin
      n_errors++;
      $display("FAIL async_pre got wr=%b d=%h p=%0d exp 1 60 1",
               a_wr, a_data, a_pend);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_grant, a_pend, a_wr, a_sof, a_eof, a_data, a_rdy0, a_rdy1,
         a_perr} !== '0) begin
      n_errors++;
      $display("FAIL async_clear got g=%b p=%0d wr=%b d=%h r=%b exp 0",
               a_grant, a_pend, a_wr, a_data, a_rdy0);
    end
    v0 = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_prio();
    test_max_frames();
    test_almost_full();
    test_phyreset();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
